seq_ram_loader: RTL and testbench
=================================

// Module: seq_ram_loader
// PURPOSE
// - Writer side of the 2-port pattern RAM: copies one SEQ_LEN-word sequence from pattern ROM into a RAM slot.
// - Drives the RAM write port (wraddress/data/wren) on CLK_50; the RAM read side stays on slow_clk playback.
// - Triggered by the sequence-select logic (debounced pb_seq_up/dn path) with a start/busy/done handshake.
// PARAMETERS
// - DATA_W   32  word width of ROM and RAM
// - ROM_AW   10  ROM address width (1024 words)
// - RAM_AW   7   RAM address width (128 words)
// - SEQ_W    6   width of seq_num
// - SEQ_LEN  32  words per sequence; power of 2, divides 2**RAM_AW and 2**ROM_AW
// - ROM_LAT  2   ROM read latency in cycles (registered address + registered q)
// PORTS
// - CLK_50     in   1        system clock, all logic on rising edge
// - reset      in   1        asynchronous, active-high
// - start      in   1        1-cycle request, sampled only in IDLE
// - abort      in   1        synchronous cancel
// - seq_num    in   SEQ_W    sequence to copy; ROM base = seq_num*SEQ_LEN
// - ram_slot   in   RAM_AW-log2(SEQ_LEN) (2)  destination slot; RAM base = ram_slot*SEQ_LEN
// - rom_addr   out  ROM_AW   ROM read address (registered)
// - rom_q      in   DATA_W   ROM data, valid ROM_LAT cycles after rom_addr
// - wraddress  out  RAM_AW   RAM write address (registered)
// - data       out  DATA_W   RAM write data (registered)
// - wren       out  1        RAM write enable (registered)
// - busy       out  1        high from cycle after accepted start until done/abort
// - done       out  1        1-cycle pulse after last write
// - err        out  1        1-cycle pulse: start rejected (seq_num >= 2**ROM_AW/SEQ_LEN)
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, counters 0; asserted mid-copy -> wren drops at once, no done.
// - FSM: IDLE -> FETCH -> DRAIN -> IDLE. seq_num/ram_slot are latched at start.
// - IDLE + start + valid seq_num -> FETCH; busy=1, rom_addr=base on the next edge.
// - IDLE + start + invalid seq_num -> err pulse next cycle, stay IDLE, no ROM/RAM activity.
// - FETCH: rom_addr increments by 1 per cycle, SEQ_LEN addresses issued back-to-back, then -> DRAIN.
// - Valid shift register (depth ROM_LAT) tracks in-flight reads.
// - Each valid rom_q produces a registered write: wren=1, data=rom_q, wraddress=RAM base+index.
// - Timing (start sampled at edge 0): first wren high after edge 2+ROM_LAT; SEQ_LEN consecutive wren cycles.
// - Completion: after last write, done=1 and busy=0 on the same edge (edge 2+ROM_LAT+SEQ_LEN).
// - Index wraps only inside a slot: wraddress never leaves [base, base+SEQ_LEN-1]; no carry into the slot field.
// - start while busy: ignored, no queuing. start on the done edge is accepted (back-to-back copies).
// - abort (any state): next edge wren=0, busy=0, FSM IDLE, in-flight reads discarded, no done.
// - abort and start in the same cycle in IDLE: abort wins.
// - rom_addr holds its last value when idle; data and wraddress hold; only wren qualifies them.
// STRUCTURE
// - Shared package kros_pkg: width constants (DATA_W, ROM_AW, RAM_AW, SEQ_LEN) and loader state encoding (IDLE/FETCH/DRAIN).
// - One natural sub-module: lat_pipe (ROM_LAT-deep valid+index delay line); the rest is a single FSM with issue/write counters.
// TESTING
// - Copy seq 3 to slot 1: rom_addr 96..127; wren 32 cycles at wraddress 32..63 with data=ROM[96+i]; first wren at edge 4; done at edge 36.
// - start with seq_num=40: err pulse one cycle later; wren, busy, done stay 0; rom_addr unchanged.
// - start pulsed again at edge 10 of a copy: ignored; exactly 32 writes and a single done.
// - abort at the 10th wren cycle: wren=0 next edge; busy=0; no done; a new start then copies correctly.
// - reset asserted mid-FETCH between clock edges: outputs 0 immediately; after release, IDLE and next copy correct.
// - start on the done edge (seq 0 slot 3, then seq 31 slot 0): second copy is contiguous; wraddress 96..127 then 0..31.

Source files
------------

// File: rtl/kros_pkg.sv
// rtl/kros_pkg.sv - shared widths and loader state encoding for the pattern RAM loader
package kros_pkg;

  localparam int DATA_W  = 32;
  localparam int ROM_AW  = 10;
  localparam int RAM_AW  = 7;
  localparam int SEQ_W   = 6;
  localparam int SEQ_LEN = 32;
  localparam int ROM_LAT = 2;

  typedef logic [1:0] ld_state_t;

  localparam ld_state_t ST_IDLE  = 2'd0;
  localparam ld_state_t ST_FETCH = 2'd1;
  localparam ld_state_t ST_DRAIN = 2'd2;

  // A sequence exists only if its whole SEQ_LEN window lies inside the ROM.
  function automatic logic seq_fits(input int seq, input int n_seq);
    return (seq < n_seq);
  endfunction

endpackage

// File: rtl/lat_pipe.sv
// rtl/lat_pipe.sv - valid+index delay line matching the ROM read latency
module lat_pipe #(
  parameter int DEPTH = kros_pkg::ROM_LAT,
  parameter int IDX_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [IDX_W-1:0] i_index,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_index
);

  logic [DEPTH-1:0] r_valid;
  logic [IDX_W-1:0] r_index [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_index[i] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid & ~i_flush;
      r_index[0] <= i_index;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1] & ~i_flush;
        r_index[i] <= r_index[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_index = r_index[DEPTH-1];

endmodule

// File: rtl/seq_ram_loader.sv
// rtl/seq_ram_loader.sv - copies one SEQ_LEN-word ROM sequence into a pattern-RAM slot
// One FSM issues back-to-back ROM reads; lat_pipe lines each index up with rom_q for the write.
module seq_ram_loader #(
  parameter int DATA_W  = kros_pkg::DATA_W,
  parameter int ROM_AW  = kros_pkg::ROM_AW,
  parameter int RAM_AW  = kros_pkg::RAM_AW,
  parameter int SEQ_W   = kros_pkg::SEQ_W,
  parameter int SEQ_LEN = kros_pkg::SEQ_LEN,
  parameter int ROM_LAT = kros_pkg::ROM_LAT
) (
  input  logic                              CLK_50,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic [SEQ_W-1:0]                  seq_num,
  input  logic [RAM_AW-$clog2(SEQ_LEN)-1:0] ram_slot,
  output logic [ROM_AW-1:0]                 rom_addr,
  input  logic [DATA_W-1:0]                 rom_q,
  output logic [RAM_AW-1:0]                 wraddress,
  output logic [DATA_W-1:0]                 data,
  output logic                              wren,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);
  import kros_pkg::*;

  localparam int IDX_W  = $clog2(SEQ_LEN);
  localparam int SLOT_W = RAM_AW - IDX_W;
  localparam int NSEQ_W = ROM_AW - IDX_W;
  localparam int N_SEQ  = 2 ** NSEQ_W;

  ld_state_t         r_state;
  logic [IDX_W-1:0]  r_cnt;
  logic [NSEQ_W-1:0] r_seq;
  logic [SLOT_W-1:0] r_slot;
  logic [ROM_AW-1:0] r_rom_addr;
  logic              r_issue_v;
  logic              r_busy;
  logic              r_done;
  logic              r_rej;
  logic              r_err;
  logic              r_wren;
  logic              r_wr_last;
  logic [RAM_AW-1:0] r_wraddress;
  logic [DATA_W-1:0] r_data;

  logic              w_seq_ok;
  logic              w_finish;
  logic              w_can_start;
  logic              w_accept;
  logic              w_reject;
  logic              w_pipe_v;
  logic [IDX_W-1:0]  w_pipe_idx;

  assign w_seq_ok    = seq_fits(int'(seq_num), N_SEQ);
  // The last write has just landed: this edge both completes and may start the next copy.
  assign w_finish    = (r_state == ST_DRAIN) && r_wren && r_wr_last;
  assign w_can_start = (r_state == ST_IDLE) || w_finish;
  assign w_accept    = w_can_start && start && !abort && w_seq_ok;
  assign w_reject    = w_can_start && start && !abort && !w_seq_ok;

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_seq      <= '0;
      r_slot     <= '0;
      r_rom_addr <= '0;
      r_issue_v  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rej      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_rej     <= 1'b0;
      r_err     <= r_rej;
      r_issue_v <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_rej <= w_reject;
            if (w_accept) begin
              r_state <= ST_FETCH;
              r_cnt   <= '0;
              r_seq   <= seq_num[NSEQ_W-1:0];
              r_slot  <= ram_slot;
            end
          end
          ST_FETCH: begin
            r_rom_addr <= {r_seq, r_cnt};
            r_issue_v  <= 1'b1;
            r_busy     <= 1'b1;
            r_cnt      <= r_cnt + 1'b1;
            if (r_cnt == IDX_W'(SEQ_LEN - 1)) begin
              r_state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (w_finish) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_rej   <= w_reject;
              r_state <= ST_IDLE;
              if (w_accept) begin
                r_state <= ST_FETCH;
                r_cnt   <= '0;
                r_seq   <= seq_num[NSEQ_W-1:0];
                r_slot  <= ram_slot;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  lat_pipe #(
    .DEPTH (ROM_LAT),
    .IDX_W (IDX_W)
  ) u_lat_pipe (
    .i_clk   (CLK_50),
    .i_rst   (reset),
    .i_flush (abort),
    .i_valid (r_issue_v),
    .i_index (r_rom_addr[IDX_W-1:0]),
    .o_valid (w_pipe_v),
    .o_index (w_pipe_idx)
  );

  // Write stage: the slot field comes from the latched slot, so the index can never carry into it.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_wren      <= 1'b0;
      r_wr_last   <= 1'b0;
      r_wraddress <= '0;
      r_data      <= '0;
    end else if (abort) begin
      r_wren    <= 1'b0;
      r_wr_last <= 1'b0;
    end else begin
      r_wren    <= w_pipe_v;
      r_wr_last <= w_pipe_v && (w_pipe_idx == IDX_W'(SEQ_LEN - 1));
      if (w_pipe_v) begin
        r_data      <= rom_q;
        r_wraddress <= {r_slot, w_pipe_idx};
      end
    end
  end

  assign rom_addr  = r_rom_addr;
  assign wraddress = r_wraddress;
  assign data      = r_data;
  assign wren      = r_wren;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_seq_ram_loader.sv
// tb/tb_seq_ram_loader.sv - scoreboard bench for seq_ram_loader against a ROM/RAM copy model
module tb_seq_ram_loader;

  localparam int DATA_W  = 32;
  localparam int ROM_AW  = 10;
  localparam int RAM_AW  = 7;
  localparam int SEQ_W   = 6;
  localparam int SEQ_LEN = 32;
  localparam int SLOT_W  = 2;
  localparam int N_SEQ   = 32;

  typedef struct {
    int                at;
    logic [RAM_AW-1:0] addr;
    logic [DATA_W-1:0] d;
  } wr_t;

  typedef struct {
    int                at;
    logic [ROM_AW-1:0] addr;
  } ra_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [SEQ_W-1:0]  seq_num = '0;
  logic [SLOT_W-1:0] ram_slot = '0;
  logic [ROM_AW-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q = '0;
  logic [RAM_AW-1:0] wraddress;
  logic [DATA_W-1:0] data;
  logic              wren, busy, done, err;

  logic [DATA_W-1:0] rom_mem [1 << ROM_AW];
  logic [ROM_AW-1:0] rom_a_q = '0;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  wr_t wr_q[$];
  ra_t ra_q[$];
  int  done_q[$];
  int  err_q[$];
  int  busy_end = 0;
  int  b_from = 0;
  int  b_to = -1;
  int  last_rom = 0;

  seq_ram_loader dut (
    .CLK_50    (clk),
    .reset     (rst),
    .start     (start),
    .abort     (abort),
    .seq_num   (seq_num),
    .ram_slot  (ram_slot),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .wraddress (wraddress),
    .data      (data),
    .wren      (wren),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rom_a_q <= rom_addr;
    rom_q   <= rom_mem[rom_a_q];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, cyc);
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic goto_edge(input int t);
    do step(); while (cyc + 1 < t);
  endtask

  task automatic do_abort(input int a);
    while (wr_q.size() > 0 && wr_q[$].at >= a) void'(wr_q.pop_back());
    while (ra_q.size() > 0 && ra_q[$].at >= a) void'(ra_q.pop_back());
    while (done_q.size() > 0 && done_q[$] >= a) void'(done_q.pop_back());
    if (b_to > a - 1) b_to = a - 1;
    busy_end = a + 1;
  endtask

  task automatic model_reset();
    wr_q.delete();
    ra_q.delete();
    done_q.delete();
    err_q.delete();
    busy_end = 0;
    b_from   = 0;
    b_to     = -1;
    last_rom = 0;
  endtask

  // Drive a one-cycle start; the model decides acceptance from its own view of busy time.
  task automatic issue(input int sq, input int sl, output int e);
    seq_num  = SEQ_W'(sq);
    ram_slot = SLOT_W'(sl);
    start    = 1'b1;
    e        = cyc + 1;
    if (!abort && e >= busy_end) begin
      if (sq < N_SEQ) begin
        for (int k = 0; k < SEQ_LEN; k++) begin
          ra_q.push_back('{at: e + 1 + k, addr: ROM_AW'(sq * SEQ_LEN + k)});
          wr_q.push_back('{at: e + 4 + k, addr: RAM_AW'(sl * SEQ_LEN + k),
                           d: rom_mem[sq * SEQ_LEN + k]});
        end
        done_q.push_back(e + 4 + SEQ_LEN);
        b_from   = e + 1;
        b_to     = e + 3 + SEQ_LEN;
        busy_end = e + 4 + SEQ_LEN;
        last_rom = sq * SEQ_LEN + SEQ_LEN - 1;
      end else begin
        err_q.push_back(e + 1);
      end
    end
    step();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    do_abort(cyc + 1);
    step();
    abort = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_wraddress"}, wraddress, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_wren"}, wren, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  always @(negedge clk) begin : monitor
    wr_t w;
    ra_t r;
    logic exp_done, exp_err;
    if (!rst) begin
      if (wr_q.size() > 0 && wr_q[0].at == cyc) begin
        w = wr_q.pop_front();
        chk("wren", wren, 1);
        chk("wraddress", wraddress, w.addr);
        chk("data", data, w.d);
      end else if (wren) begin
        chk("unexpected_wren", wren, 0);
      end
      if (ra_q.size() > 0 && ra_q[0].at == cyc) begin
        r = ra_q.pop_front();
        chk("rom_addr", rom_addr, r.addr);
      end
      exp_done = (done_q.size() > 0 && done_q[0] == cyc);
      if (exp_done) void'(done_q.pop_front());
      if (done || exp_done) chk("done", done, exp_done);
      exp_err = (err_q.size() > 0 && err_q[0] == cyc);
      if (exp_err) void'(err_q.pop_front());
      if (err || exp_err) chk("err", err, exp_err);
      chk("busy", busy, (cyc >= b_from && cyc <= b_to));
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: run did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int s, s2, e, mode, sq, sl;
    bit b2b;
    for (int i = 0; i < (1 << ROM_AW); i++) rom_mem[i] = $urandom;

    #1 rst = 1'b1;
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Copy seq 3 into slot 1 with timing checks on the first issue cycle.
    issue(3, 1, s);
    goto_edge(s + 2);
    chk("t1_busy", busy, 1);
    chk("t1_rom_base", rom_addr, 96);
    goto_edge(s + 40);

    // Out-of-range sequence: error pulse only, ROM address holds.
    issue(40, 0, s);
    goto_edge(s + 4);
    chk("t2_rom_hold", rom_addr, last_rom);
    chk("t2_busy", busy, 0);

    // Stray start during a copy is ignored.
    step();
    issue(7, 2, s);
    goto_edge(s + 10);
    issue(9, 0, e);
    goto_edge(s + 40);

    // Abort on the 10th write cycle, then a clean copy.
    issue(5, 3, s);
    goto_edge(s + 14);
    pulse_abort();
    chk("t4_busy", busy, 0);
    chk("t4_wren", wren, 0);
    issue(12, 1, s);
    goto_edge(s + 40);

    // Abort and start together in IDLE: abort wins.
    abort = 1'b1;
    do_abort(cyc + 1);
    issue(4, 1, s);
    abort = 1'b0;
    goto_edge(s + 6);
    chk("t7_busy", busy, 0);

    // Asynchronous reset in the middle of FETCH.
    step();
    issue(20, 2, s);
    goto_edge(s + 10);
    #1 rst = 1'b1;
    #1 chk_all_zero("midreset");
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();
    issue(21, 0, s);
    goto_edge(s + 40);

    // Back-to-back: second start sampled on the done edge.
    issue(0, 3, s);
    goto_edge(s + 36);
    issue(31, 0, s2);
    goto_edge(s2 + 40);

    // Randomised copies with stray starts, aborts and back-to-back requests.
    b2b = 1'b0;
    for (int it = 0; it < 30; it++) begin
      if (!b2b) step();
      sq = $urandom_range(0, 39);
      sl = $urandom_range(0, 3);
      issue(sq, sl, s);
      mode = $urandom_range(0, 3);
      b2b  = 1'b0;
      case (mode)
        1: begin
          goto_edge(s + $urandom_range(1, 35));
          issue($urandom_range(0, 39), $urandom_range(0, 3), e);
          goto_edge(s + 40);
        end
        2: begin
          goto_edge(s + $urandom_range(1, 36));
          pulse_abort();
          goto_edge(s + 40);
        end
        3: begin
          goto_edge(s + 36);
          b2b = 1'b1;
        end
        default: goto_edge(s + 40);
      endcase
    end

    goto_edge(cyc + 45);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
